oldland_bus_arbiter: RTL
========================

Name: oldland_bus_arbiter

Overview:
- Shares the single external memory bus between three masters: debug unit memory port, data cache port, instruction cache port.
- Latches requests, grants one master per transaction and drives the bus.
- Returns a one-cycle completion, with read data and error flag, to the granted master only.
- Sits between the debug unit, the caches and the SoC bus.

Parameters:
- timeout_cycles, 1024: bus cycles to wait for bus_ack before forcing an error completion; range 1..65535.
- dbg_priority, 1: 1 = debug always wins arbitration; 0 = debug joins the round-robin.

Ports:
- clk  in  1  CPU clock.
- rst_n  in  1  asynchronous active-low reset.
- dbg_access  in  1  single-cycle request pulse from the debug unit.
- dbg_addr  in  32  debug byte address.
- dbg_width  in  2  access width: 00 = byte, 01 = half, 10 = word.
- dbg_wr_en  in  1  debug write.
- dbg_wr_val  in  32  debug write data, right-justified.
- dbg_rd_val  out  32  debug read data, right-justified, zero-extended.
- dbg_compl  out  1  debug completion pulse.
- d_access, d_addr[32], d_width[2], d_wr_en, d_wr_val[32]  in  data cache request. d_access is level and is held until d_compl.
- d_rd_val  out  32  data cache read data.
- d_compl  out  1  data cache completion pulse.
- d_error  out  1  data cache error, valid with d_compl.
- i_access, i_addr[32]  in  instruction cache request. Level; word read only.
- i_rd_val  out  32  instruction cache read data.
- i_compl  out  1  instruction cache completion pulse.
- i_error  out  1  instruction cache error, valid with i_compl.
- bus_access  out  1  bus request.
- bus_addr  out  32  word-aligned bus address.
- bus_wr_en  out  1  bus write.
- bus_bytesel  out  4  byte lane enables.
- bus_wr_val  out  32  lane-replicated write data.
- bus_rd_val  in  32  bus read data.
- bus_ack  in  1  bus completion.
- bus_error  in  1  bus error, valid with bus_ack.
- busy  out  1  transaction in flight.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, dbg_pending 0, rr_last = icache, timeout counter 0.
- Debug request capture:
  - A dbg_access pulse sets dbg_pending and latches addr, width, wr_en and wr_val, in any state.
  - A second pulse while pending is ignored. The debug unit never issues one.
- Arbitration, in IDLE only:
  - dbg_priority=1: dbg_pending wins; otherwise round-robin between d and i.
  - Round-robin: the master not equal to rr_last wins; a lone requester wins.
  - rr_last is updated on every d/i grant.
  - dbg_priority=0: three-way round-robin, order dbg -> d -> i.
- State machine:
  - IDLE -> BUS when any request is present. Grant is registered, so bus_access rises the cycle after a request is seen.
  - BUS: hold bus_access and all bus outputs stable.
    - On bus_ack, capture bus_rd_val and bus_error, drop bus_access, go to RESP.
    - If the counter reaches timeout_cycles - 1 without ack, go to RESP with error = 1 and rd_val = 32'hdeadbeef.
  - RESP: pulse exactly one compl for the granted master, with rd_val and error.
    - Clear dbg_pending if debug was granted.
    - Return to IDLE. A new grant is possible the next cycle, giving a minimum of 3 cycles per transaction.
- Lane steering, from addr[1:0] and width:
  - Byte: bytesel = 1 << addr[1:0]; write data replicated to all 4 lanes.
  - Half: bytesel = addr[1] ? 1100 : 0011; data replicated to both halves.
  - Word: bytesel = 1111.
  - Reads: selected lane shifted down and zero-extended.
  - Misaligned half/word (addr[0], or addr[1:0] != 0 for word): no bus cycle; IDLE -> RESP directly with error = 1.
- Debug has no error port. An errored debug read returns 32'hdeadbeef.
- i and d requests dropped by the master before completion are illegal. Behaviour is undefined; flag with an assertion.
- busy = state != IDLE.
- Reset mid-transaction: immediate return to IDLE. Pending debug request discarded; no compl issued.

Decomposition:
- Package oldland_bus_pkg:
  - width encodings WIDTH_BYTE/HALF/WORD;
  - master ids MASTER_DBG/D/I;
  - one-hot state constants;
  - ERR_RD_VAL.
- Sub-module oldland_lane_steer: combinational bytesel, write replication, read extraction and misalignment detect. Instantiated once for bus outputs and reused for the read path.

Test Plan:
- Debug word read, addr 0x100: dbg_access pulse with dbg_width=10, bus acks 2 cycles later with 0x12345678 -> bus_addr=0x100, bytesel=1111, dbg_compl 1 cycle, dbg_rd_val=0x12345678.
- Byte write via d, addr 0x203, data 0xa5 -> bytesel=1000, bus_wr_val=0xa5a5a5a5, d_compl with d_error=0.
- i and d both held continuously, each acked immediately -> grants alternate i, d, i, d; debug pulse mid-stream wins the next IDLE when dbg_priority=1.
- timeout_cycles=8, no bus_ack -> bus_access high exactly 8 cycles, i_compl with i_error=1 and rd_val 0xdeadbeef.
- Half read via d at 0x2001 -> no bus_access, d_compl with d_error=1 within 2 cycles.
- rst_n asserted during BUS -> bus_access low immediately, no compl pulses; after release, a fresh i request completes normally.

Source files
------------

// File: rtl/oldland_bus_pkg.sv
// rtl/oldland_bus_pkg.sv - shared encodings and arbitration helper for the oldland bus arbiter
package oldland_bus_pkg;

   localparam logic [1:0] WIDTH_BYTE = 2'b00;
   localparam logic [1:0] WIDTH_HALF = 2'b01;
   localparam logic [1:0] WIDTH_WORD = 2'b10;

   typedef enum logic [1:0] {
      MASTER_DBG = 2'd0,
      MASTER_D   = 2'd1,
      MASTER_I   = 2'd2
   } master_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_BUS  = 3'b010,
      ST_RESP = 3'b100
   } state_t;

   localparam logic [31:0] ERR_RD_VAL = 32'hdeadbeef;

   // Scan requesters in dbg -> d -> i order starting after the last winner.
   function automatic master_t rr_pick(input master_t last, input logic req_dbg,
                                       input logic req_d, input logic req_i);
      case (last)
         MASTER_DBG: return req_d ? MASTER_D : (req_i ? MASTER_I : MASTER_DBG);
         MASTER_D:   return req_i ? MASTER_I : (req_dbg ? MASTER_DBG : MASTER_D);
         default:    return req_dbg ? MASTER_DBG : (req_d ? MASTER_D : MASTER_I);
      endcase
   endfunction

endpackage

// File: rtl/oldland_lane_steer.sv
// rtl/oldland_lane_steer.sv - byte lane enables, write replication, read extraction, alignment check
module oldland_lane_steer
   import oldland_bus_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  width,
   input  logic [31:0] wr_val,
   input  logic [31:0] bus_rd_val,
   output logic [3:0]  bytesel,
   output logic [31:0] bus_wr_val,
   output logic [31:0] rd_val,
   output logic        misaligned
);

   logic [31:0] rd_shifted;

   assign rd_shifted = bus_rd_val >> {addr_lo, 3'b000};

   always_comb begin
      bytesel    = 4'b0000;
      bus_wr_val = wr_val;
      rd_val     = bus_rd_val;
      misaligned = 1'b0;
      case (width)
         WIDTH_BYTE: begin
            bytesel    = 4'b0001 << addr_lo;
            bus_wr_val = {4{wr_val[7:0]}};
            rd_val     = {24'h0, rd_shifted[7:0]};
         end
         WIDTH_HALF: begin
            bytesel    = addr_lo[1] ? 4'b1100 : 4'b0011;
            bus_wr_val = {2{wr_val[15:0]}};
            rd_val     = {16'h0, rd_shifted[15:0]};
            misaligned = addr_lo[0];
         end
         WIDTH_WORD: begin
            bytesel    = 4'b1111;
            misaligned = (addr_lo != 2'b00);
         end
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/oldland_bus_arbiter.sv
// rtl/oldland_bus_arbiter.sv - shares the external memory bus between debug, dcache and icache
module oldland_bus_arbiter
   import oldland_bus_pkg::*;
#(
   parameter int unsigned timeout_cycles = 1024,
   parameter bit          dbg_priority   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dbg_access,
   input  logic [31:0] dbg_addr,
   input  logic [1:0]  dbg_width,
   input  logic        dbg_wr_en,
   input  logic [31:0] dbg_wr_val,
   output logic [31:0] dbg_rd_val,
   output logic        dbg_compl,
   input  logic        d_access,
   input  logic [31:0] d_addr,
   input  logic [1:0]  d_width,
   input  logic        d_wr_en,
   input  logic [31:0] d_wr_val,
   output logic [31:0] d_rd_val,
   output logic        d_compl,
   output logic        d_error,
   input  logic        i_access,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rd_val,
   output logic        i_compl,
   output logic        i_error,
   output logic        bus_access,
   output logic [31:0] bus_addr,
   output logic        bus_wr_en,
   output logic [3:0]  bus_bytesel,
   output logic [31:0] bus_wr_val,
   input  logic [31:0] bus_rd_val,
   input  logic        bus_ack,
   input  logic        bus_error,
   output logic        busy
);

   localparam logic [15:0] TIMEOUT_LAST = 16'(timeout_cycles - 1);

   state_t      state_q, state_d;
   master_t     grant_q, grant_d, rr_last_q, rr_last_d;
   logic [15:0] timer_q, timer_d;
   logic        dbg_pending_q, dbg_pending_d;
   logic [31:0] dbg_addr_q, dbg_addr_d, dbg_wr_val_q, dbg_wr_val_d;
   logic [1:0]  dbg_width_q, dbg_width_d;
   logic        dbg_wr_en_q, dbg_wr_en_d;
   logic [1:0]  xfer_lo_q, xfer_lo_d, xfer_width_q, xfer_width_d;
   logic        bus_access_q, bus_access_d, bus_wr_en_q, bus_wr_en_d;
   logic [31:0] bus_addr_q, bus_addr_d, bus_wr_val_q, bus_wr_val_d;
   logic [3:0]  bus_bytesel_q, bus_bytesel_d;
   logic [31:0] dbg_rd_val_q, dbg_rd_val_d, d_rd_val_q, d_rd_val_d, i_rd_val_q, i_rd_val_d;
   logic        dbg_compl_q, dbg_compl_d, d_compl_q, d_compl_d, i_compl_q, i_compl_d;
   logic        d_error_q, d_error_d, i_error_q, i_error_d;

   master_t     cand, owner;
   logic        any_req, fin, fin_err;
   logic [31:0] fin_rd;
   logic [31:0] cand_addr, cand_wr_val;
   logic [1:0]  cand_width;
   logic        cand_wr_en;
   logic [1:0]  steer_lo, steer_width;
   logic [3:0]  steer_bytesel;
   logic [31:0] steer_wr_val, steer_rd_val;
   logic        steer_misaligned;

   assign any_req = dbg_pending_q | d_access | i_access;
   assign cand    = (dbg_priority && dbg_pending_q) ? MASTER_DBG
                                                    : rr_pick(rr_last_q, dbg_pending_q, d_access, i_access);

   always_comb begin
      cand_addr   = i_addr;
      cand_width  = WIDTH_WORD;
      cand_wr_en  = 1'b0;
      cand_wr_val = 32'h0;
      case (cand)
         MASTER_DBG: begin
            cand_addr   = dbg_addr_q;
            cand_width  = dbg_width_q;
            cand_wr_en  = dbg_wr_en_q;
            cand_wr_val = dbg_wr_val_q;
         end
         MASTER_D: begin
            cand_addr   = d_addr;
            cand_width  = d_width;
            cand_wr_en  = d_wr_en;
            cand_wr_val = d_wr_val;
         end
         default: ;
      endcase
   end

   // One steering instance: fed by the candidate while arbitrating, by the latched transfer otherwise.
   assign steer_lo    = (state_q == ST_IDLE) ? cand_addr[1:0] : xfer_lo_q;
   assign steer_width = (state_q == ST_IDLE) ? cand_width     : xfer_width_q;

   oldland_lane_steer u_steer (
      .addr_lo    (steer_lo),
      .width      (steer_width),
      .wr_val     (cand_wr_val),
      .bus_rd_val (bus_rd_val),
      .bytesel    (steer_bytesel),
      .bus_wr_val (steer_wr_val),
      .rd_val     (steer_rd_val),
      .misaligned (steer_misaligned)
   );

   assign owner = (state_q == ST_IDLE) ? cand : grant_q;

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_last_d     = rr_last_q;
      timer_d       = timer_q;
      dbg_pending_d = dbg_pending_q;
      dbg_addr_d    = dbg_addr_q;
      dbg_width_d   = dbg_width_q;
      dbg_wr_en_d   = dbg_wr_en_q;
      dbg_wr_val_d  = dbg_wr_val_q;
      xfer_lo_d     = xfer_lo_q;
      xfer_width_d  = xfer_width_q;
      bus_access_d  = bus_access_q;
      bus_addr_d    = bus_addr_q;
      bus_wr_en_d   = bus_wr_en_q;
      bus_bytesel_d = bus_bytesel_q;
      bus_wr_val_d  = bus_wr_val_q;
      dbg_rd_val_d  = dbg_rd_val_q;
      d_rd_val_d    = d_rd_val_q;
      i_rd_val_d    = i_rd_val_q;
      d_error_d     = d_error_q;
      i_error_d     = i_error_q;
      dbg_compl_d   = 1'b0;
      d_compl_d     = 1'b0;
      i_compl_d     = 1'b0;
      fin           = 1'b0;
      fin_err       = 1'b0;
      fin_rd        = ERR_RD_VAL;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_d = cand;
               if (!dbg_priority || cand != MASTER_DBG) rr_last_d = cand;
               if (steer_misaligned) begin
                  state_d = ST_RESP;
                  fin     = 1'b1;
                  fin_err = 1'b1;
               end else begin
                  state_d       = ST_BUS;
                  timer_d       = 16'h0;
                  xfer_lo_d     = cand_addr[1:0];
                  xfer_width_d  = cand_width;
                  bus_access_d  = 1'b1;
                  bus_addr_d    = {cand_addr[31:2], 2'b00};
                  bus_wr_en_d   = cand_wr_en;
                  bus_bytesel_d = steer_bytesel;
                  bus_wr_val_d  = steer_wr_val;
               end
            end
         end
         ST_BUS: begin
            if (bus_ack || timer_q == TIMEOUT_LAST) begin
               state_d       = ST_RESP;
               fin           = 1'b1;
               fin_err       = bus_ack ? bus_error : 1'b1;
               fin_rd        = bus_ack ? steer_rd_val : ERR_RD_VAL;
               bus_access_d  = 1'b0;
               bus_addr_d    = 32'h0;
               bus_wr_en_d   = 1'b0;
               bus_bytesel_d = 4'h0;
               bus_wr_val_d  = 32'h0;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = 16'h0;
            if (grant_q == MASTER_DBG) dbg_pending_d = 1'b0;
         end
      endcase

      if (fin) begin
         case (owner)
            MASTER_DBG: begin
               dbg_compl_d  = 1'b1;
               dbg_rd_val_d = fin_err ? ERR_RD_VAL : fin_rd;
            end
            MASTER_D: begin
               d_compl_d  = 1'b1;
               d_rd_val_d = fin_rd;
               d_error_d  = fin_err;
            end
            default: begin
               i_compl_d  = 1'b1;
               i_rd_val_d = fin_rd;
               i_error_d  = fin_err;
            end
         endcase
      end

      if (dbg_access && !dbg_pending_q) begin
         dbg_pending_d = 1'b1;
         dbg_addr_d    = dbg_addr;
         dbg_width_d   = dbg_width;
         dbg_wr_en_d   = dbg_wr_en;
         dbg_wr_val_d  = dbg_wr_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         grant_q       <= MASTER_I;
         rr_last_q     <= MASTER_I;
         timer_q       <= 16'h0;
         dbg_pending_q <= 1'b0;
         dbg_addr_q    <= 32'h0;
         dbg_width_q   <= 2'b00;
         dbg_wr_en_q   <= 1'b0;
         dbg_wr_val_q  <= 32'h0;
         xfer_lo_q     <= 2'b00;
         xfer_width_q  <= 2'b00;
         bus_access_q  <= 1'b0;
         bus_addr_q    <= 32'h0;
         bus_wr_en_q   <= 1'b0;
         bus_bytesel_q <= 4'h0;
         bus_wr_val_q  <= 32'h0;
         dbg_rd_val_q  <= 32'h0;
         d_rd_val_q    <= 32'h0;
         i_rd_val_q    <= 32'h0;
         dbg_compl_q   <= 1'b0;
         d_compl_q     <= 1'b0;
         i_compl_q     <= 1'b0;
         d_error_q     <= 1'b0;
         i_error_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         rr_last_q     <= rr_last_d;
         timer_q       <= timer_d;
         dbg_pending_q <= dbg_pending_d;
         dbg_addr_q    <= dbg_addr_d;
         dbg_width_q   <= dbg_width_d;
         dbg_wr_en_q   <= dbg_wr_en_d;
         dbg_wr_val_q  <= dbg_wr_val_d;
         xfer_lo_q     <= xfer_lo_d;
         xfer_width_q  <= xfer_width_d;
         bus_access_q  <= bus_access_d;
         bus_addr_q    <= bus_addr_d;
         bus_wr_en_q   <= bus_wr_en_d;
         bus_bytesel_q <= bus_bytesel_d;
         bus_wr_val_q  <= bus_wr_val_d;
         dbg_rd_val_q  <= dbg_rd_val_d;
         d_rd_val_q    <= d_rd_val_d;
         i_rd_val_q    <= i_rd_val_d;
         dbg_compl_q   <= dbg_compl_d;
         d_compl_q     <= d_compl_d;
         i_compl_q     <= i_compl_d;
         d_error_q     <= d_error_d;
         i_error_q     <= i_error_d;
      end
   end

   assign dbg_rd_val  = dbg_rd_val_q;
   assign dbg_compl   = dbg_compl_q;
   assign d_rd_val    = d_rd_val_q;
   assign d_compl     = d_compl_q;
   assign d_error     = d_error_q;
   assign i_rd_val    = i_rd_val_q;
   assign i_compl     = i_compl_q;
   assign i_error     = i_error_q;
   assign bus_access  = bus_access_q;
   assign bus_addr    = bus_addr_q;
   assign bus_wr_en   = bus_wr_en_q;
   assign bus_bytesel = bus_bytesel_q;
   assign bus_wr_val  = bus_wr_val_q;
   assign busy        = (state_q != ST_IDLE);

   // Cache masters must hold their request for the whole bus cycle.
   a_d_held: assert property (@(posedge clk) disable iff (!rst_n)
                              (state_q == ST_BUS && grant_q == MASTER_D) |-> d_access);
   a_i_held: assert property (@(posedge clk) disable iff (!rst_n)
                              (state_q == ST_BUS && grant_q == MASTER_I) |-> i_access);

endmodule
